// File: rtl/freelist_ckpt_ctrl.sv
// freelist_ckpt_ctrl: branch checkpoint ring for the rename free list.
// Each renamed branch snapshots the free-list head it will need on a
// mispredict. Entries release in order once resolved correct; a mispredict
// truncates the ring at the offending tag and returns its saved head.
// Optional statistics counters: define FLCKPT_STATS_EN to build them.
module freelist_ckpt_ctrl #(
  parameter int SIZE_FREE_LIST = 96,
  parameter int FL_LOG         = 7,
  parameter int NUM_CKPT       = 8,
  parameter int CKPT_LOG       = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                recoverFlag_i,
  input  logic                branchValid_i,
  input  logic [FL_LOG-1:0]   freeListHead_i,
  input  logic [2:0]          branchOffset_i,
  output logic [CKPT_LOG-1:0] ckptTag_o,
  output logic                ckptFull_o,
  input  logic                resolveValid_i,
  input  logic [CKPT_LOG-1:0] resolveTag_i,
  input  logic                mispredict_i,
  output logic                ctrlVerified_o,
  output logic                flagRecoverEX_o,
  output logic [FL_LOG-1:0]   freeListHeadCp_o,
  output logic [CKPT_LOG:0]   ckptCount_o,
  output logic [15:0]         fullStallCnt_o,
  output logic [15:0]         recoverCnt_o
);

  // Saved head values carry no reset: an entry is only read while valid.
  logic [FL_LOG-1:0]   r_ckpt_head [NUM_CKPT];
  logic [NUM_CKPT-1:0] r_valid;
  logic [NUM_CKPT-1:0] r_resolved;
  logic [CKPT_LOG-1:0] r_head;
  logic [CKPT_LOG-1:0] r_tail;
  logic [CKPT_LOG:0]   r_count;
  logic                r_ctrl_verified;
  logic                r_flag_recover;
  logic [FL_LOG-1:0]   r_head_cp;

  logic                w_full;
  logic [FL_LOG:0]     w_sum;
  logic [FL_LOG:0]     w_sum_wrap;
  logic [FL_LOG-1:0]   w_new_head;
  logic                w_res_hit;
  logic                w_mispred;
  logic                w_correct;
  logic                w_alloc;
  logic                w_release;
  logic [CKPT_LOG-1:0] w_res_age;

  assign w_full = (r_count == (CKPT_LOG+1)'(NUM_CKPT));

  // Head after this branch's pops, wrapped once around the free list.
  assign w_sum      = {1'b0, freeListHead_i} + (FL_LOG+1)'(branchOffset_i);
  assign w_sum_wrap = w_sum - (FL_LOG+1)'(SIZE_FREE_LIST);
  assign w_new_head = (w_sum >= (FL_LOG+1)'(SIZE_FREE_LIST)) ?
                      w_sum_wrap[FL_LOG-1:0] : w_sum[FL_LOG-1:0];

  // A full flush outranks everything; resolves on dead tags are ignored.
  assign w_res_hit = resolveValid_i & r_valid[resolveTag_i] & ~recoverFlag_i;
  assign w_mispred = w_res_hit & mispredict_i;
  assign w_correct = w_res_hit & ~mispredict_i;
  assign w_alloc   = branchValid_i & ~stall_i & ~w_full & ~w_mispred & ~recoverFlag_i;
  assign w_release = r_valid[r_head] & r_resolved[r_head] & ~w_mispred & ~recoverFlag_i;
  // Distance of the mispredicted tag from the oldest live entry.
  assign w_res_age = resolveTag_i - r_head;

  assign ckptTag_o        = r_tail;
  assign ckptFull_o       = w_full;
  assign ckptCount_o      = r_count;
  assign ctrlVerified_o   = r_ctrl_verified;
  assign flagRecoverEX_o  = r_flag_recover;
  assign freeListHeadCp_o = r_head_cp;

  // Capture the snapshot head into the tail slot on allocation.
  always_ff @(posedge clk) begin
    if (w_alloc) r_ckpt_head[r_tail] <= w_new_head;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CKPT; gi++) begin : g_entry
      logic [CKPT_LOG-1:0] w_age;
      assign w_age = CKPT_LOG'(gi) - r_head;

      // Per-entry valid/resolved: flush, truncate younger, alloc, release, resolve.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_valid[gi]    <= 1'b0;
          r_resolved[gi] <= 1'b0;
        end else if (recoverFlag_i) begin
          r_valid[gi]    <= 1'b0;
          r_resolved[gi] <= 1'b0;
        end else if (w_mispred && (w_age >= w_res_age)) begin
          r_valid[gi]    <= 1'b0;
          r_resolved[gi] <= 1'b0;
        end else if (w_alloc && (r_tail == CKPT_LOG'(gi))) begin
          r_valid[gi]    <= 1'b1;
          r_resolved[gi] <= 1'b0;
        end else if (w_release && (r_head == CKPT_LOG'(gi))) begin
          r_valid[gi]    <= 1'b0;
          r_resolved[gi] <= 1'b0;
        end else if (w_correct && (resolveTag_i == CKPT_LOG'(gi))) begin
          r_resolved[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Ring pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (recoverFlag_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mispred) begin
      r_tail  <= resolveTag_i;
      r_count <= {1'b0, w_res_age};
    end else begin
      if (w_alloc)   r_tail <= r_tail + 1'b1;
      if (w_release) r_head <= r_head + 1'b1;
      case ({w_alloc, w_release})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle resolution pulses and the restored head for the free list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl_verified <= 1'b0;
      r_flag_recover  <= 1'b0;
      r_head_cp       <= '0;
    end else begin
      r_ctrl_verified <= w_res_hit;
      r_flag_recover  <= w_mispred;
      if (w_mispred) r_head_cp <= r_ckpt_head[resolveTag_i];
    end
  end

`ifdef FLCKPT_STATS_EN
  logic [15:0] r_full_stall_cnt;
  logic [15:0] r_recover_cnt;

  // Saturating counters of full-ring stalls and recovery pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full_stall_cnt <= '0;
      r_recover_cnt    <= '0;
    end else if (recoverFlag_i) begin
      r_full_stall_cnt <= '0;
      r_recover_cnt    <= '0;
    end else begin
      if (branchValid_i && w_full && (r_full_stall_cnt != 16'hFFFF))
        r_full_stall_cnt <= r_full_stall_cnt + 1'b1;
      if (r_flag_recover && (r_recover_cnt != 16'hFFFF))
        r_recover_cnt <= r_recover_cnt + 1'b1;
    end
  end

  assign fullStallCnt_o = r_full_stall_cnt;
  assign recoverCnt_o   = r_recover_cnt;
`else
  assign fullStallCnt_o = 16'h0000;
  assign recoverCnt_o   = 16'h0000;
`endif

endmodule

// File: tb/tb_freelist_ckpt_ctrl.sv
// Testbench for freelist_ckpt_ctrl: directed stimulus with a scoreboard queue
// of expected outputs, drained and compared after each clock edge.
module tb_freelist_ckpt_ctrl;
  localparam int FL_LOG   = 7;
  localparam int CKPT_LOG = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                stall_i;
  logic                recoverFlag_i;
  logic                branchValid_i;
  logic [FL_LOG-1:0]   freeListHead_i;
  logic [2:0]          branchOffset_i;
  logic [CKPT_LOG-1:0] ckptTag_o;
  logic                ckptFull_o;
  logic                resolveValid_i;
  logic [CKPT_LOG-1:0] resolveTag_i;
  logic                mispredict_i;
  logic                ctrlVerified_o;
  logic                flagRecoverEX_o;
  logic [FL_LOG-1:0]   freeListHeadCp_o;
  logic [CKPT_LOG:0]   ckptCount_o;
  logic [15:0]         fullStallCnt_o;
  logic [15:0]         recoverCnt_o;

  freelist_ckpt_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .recoverFlag_i    (recoverFlag_i),
    .branchValid_i    (branchValid_i),
    .freeListHead_i   (freeListHead_i),
    .branchOffset_i   (branchOffset_i),
    .ckptTag_o        (ckptTag_o),
    .ckptFull_o       (ckptFull_o),
    .resolveValid_i   (resolveValid_i),
    .resolveTag_i     (resolveTag_i),
    .mispredict_i     (mispredict_i),
    .ctrlVerified_o   (ctrlVerified_o),
    .flagRecoverEX_o  (flagRecoverEX_o),
    .freeListHeadCp_o (freeListHeadCp_o),
    .ckptCount_o      (ckptCount_o),
    .fullStallCnt_o   (fullStallCnt_o),
    .recoverCnt_o     (recoverCnt_o)
  );

  always #5 clk = ~clk;

`ifdef FLCKPT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    int unsigned val;
  } exp_t;
  exp_t sb[$];

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  function automatic int unsigned sample(input string name);
    if      (name == "tag")        return 32'(ckptTag_o);
    else if (name == "full")       return 32'(ckptFull_o);
    else if (name == "count")      return 32'(ckptCount_o);
    else if (name == "verified")   return 32'(ctrlVerified_o);
    else if (name == "recover")    return 32'(flagRecoverEX_o);
    else if (name == "headcp")     return 32'(freeListHeadCp_o);
    else if (name == "fullstall")  return 32'(fullStallCnt_o);
    else if (name == "recovercnt") return 32'(recoverCnt_o);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic push_exp(input string name, input int unsigned val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.name, sample(e.name), e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle_inputs();
    stall_i        = 1'b0;
    recoverFlag_i  = 1'b0;
    branchValid_i  = 1'b0;
    freeListHead_i = '0;
    branchOffset_i = '0;
    resolveValid_i = 1'b0;
    resolveTag_i   = '0;
    mispredict_i   = 1'b0;
  endtask

  task automatic alloc(input int head, input int off);
    idle_inputs();
    branchValid_i  = 1'b1;
    freeListHead_i = FL_LOG'(head);
    branchOffset_i = 3'(off);
    step();
  endtask

  task automatic resolve(input int tag, input bit mis);
    idle_inputs();
    resolveValid_i = 1'b1;
    resolveTag_i   = CKPT_LOG'(tag);
    mispredict_i   = mis;
  endtask

  int tbl_head [4] = '{92, 95, 10, 94};
  int tbl_off  [4] = '{4, 0, 1, 4};
  int tbl_exp  [4] = '{0, 95, 11, 2};

  initial begin
    idle_inputs();
    reset = 1'b1;
    #12;
    push_exp("count", 0); push_exp("tag", 0); push_exp("full", 0);
    push_exp("verified", 0); push_exp("recover", 0); push_exp("headcp", 0);
    push_exp("fullstall", 0); push_exp("recovercnt", 0);
    drain();
    @(negedge clk);
    reset = 1'b0;

    // Fill the ring: tags 0..7, then three refused allocations while full.
    for (int i = 0; i < 8; i++) begin
      push_exp("tag", i);
      drain();
      alloc(10, 1);
    end
    push_exp("full", 1); push_exp("count", 8); push_exp("tag", 0);
    drain();
    alloc(10, 1);
    push_exp("tag", 0); push_exp("count", 8);
    drain();
    alloc(10, 1);
    alloc(10, 1);
    push_exp("fullstall", STATS ? 3 : 0); push_exp("count", 8);
    drain();

    // Mispredict on the youngest, then on tag 5; dead-tag resolve ignored.
    resolve(7, 1);
    push_exp("verified", 1); push_exp("recover", 1); push_exp("headcp", 11);
    push_exp("count", 7); push_exp("tag", 7); push_exp("full", 0);
    step();
    idle_inputs();
    push_exp("verified", 0); push_exp("recover", 0); push_exp("recovercnt", STATS ? 1 : 0);
    step();
    resolve(5, 1);
    push_exp("count", 5); push_exp("tag", 5); push_exp("recover", 1);
    step();
    idle_inputs();
    push_exp("recovercnt", STATS ? 2 : 0);
    step();
    resolve(6, 1);
    push_exp("verified", 0); push_exp("recover", 0); push_exp("count", 5);
    step();
    idle_inputs();
    push_exp("recovercnt", STATS ? 2 : 0);
    step();

    // Flush with a simultaneous mispredict resolve.
    resolve(0, 1);
    recoverFlag_i = 1'b1;
    push_exp("count", 0); push_exp("tag", 0); push_exp("verified", 0);
    push_exp("recover", 0); push_exp("fullstall", 0); push_exp("recovercnt", 0);
    step();

    // Head wrap around the free list, recovered via mispredict.
    for (int k = 0; k < 4; k++) begin
      alloc(tbl_head[k], tbl_off[k]);
      resolve(0, 1);
      push_exp("recover", 1); push_exp("headcp", tbl_exp[k]); push_exp("count", 0);
      step();
      idle_inputs();
      step();
    end

    // In-order release: resolve tag 1 then tag 0.
    alloc(10, 1); alloc(10, 1); alloc(10, 1);
    push_exp("count", 3);
    drain();
    resolve(1, 0);
    push_exp("count", 3); push_exp("verified", 1); push_exp("recover", 0); push_exp("headcp", 2);
    step();
    resolve(0, 0);
    push_exp("count", 3); push_exp("verified", 1);
    step();
    idle_inputs();
    push_exp("count", 2); push_exp("verified", 0);
    step();
    push_exp("count", 1);
    step();
    recoverFlag_i = 1'b1;
    push_exp("count", 0);
    step();

    // Mispredict on tag 2 drops a same-cycle allocation.
    for (int i = 0; i < 5; i++) alloc(10, 1);
    resolve(2, 1);
    branchValid_i  = 1'b1;
    freeListHead_i = 7'd50;
    push_exp("tag", 2); push_exp("count", 2); push_exp("full", 0);
    push_exp("recover", 1); push_exp("headcp", 11);
    step();
    resolve(3, 0);
    push_exp("verified", 0); push_exp("count", 2);
    step();
    alloc(10, 1);
    push_exp("tag", 3); push_exp("count", 3);
    drain();

    // Asynchronous reset between clock edges.
    alloc(10, 1);
    #2;
    reset = 1'b1;
    #1;
    push_exp("count", 0); push_exp("tag", 0); push_exp("headcp", 0);
    push_exp("full", 0); push_exp("recover", 0);
    drain();
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    push_exp("count", 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/freelist_ckpt_ctrl.md
FREELIST_CKPT_CTRL -- requirements
Module: freelist_ckpt_ctrl

Interface
REQ-001 The block SHALL have these parameters: SIZE_FREE_LIST, 96, free-list entries; FL_LOG, 7, free-list index width; NUM_CKPT, 8, checkpoint slots (power of two); CKPT_LOG, 3, log2(NUM_CKPT).
REQ-002 The block SHALL have these ports:
 - clk  in  1  sole clock, rising edge.
 - reset  in  1  asynchronous, active-high.
 - stall_i  in  1  rename stalled.
 - recoverFlag_i  in  1  full pipeline flush.
 - branchValid_i  in  1  one branch renamed this cycle.
 - freeListHead_i  in  FL_LOG  current free-list head.
 - branchOffset_i  in  3  pops preceding and including the branch in the bundle (0..4).
 - ckptTag_o  out  CKPT_LOG  tag given to the branch.
 - ckptFull_o  out  1  no free slot.
 - resolveValid_i  in  1  branch resolved.
 - resolveTag_i  in  CKPT_LOG  resolved tag.
 - mispredict_i  in  1  resolution was a mispredict.
 - ctrlVerified_o  out  1  resolution pulse to the free list.
 - flagRecoverEX_o  out  1  mispredict pulse to the free list.
 - freeListHeadCp_o  out  FL_LOG  restored head.
 - ckptCount_o  out  CKPT_LOG+1  live checkpoints.
 - fullStallCnt_o  out  16  full-stall statistic.
 - recoverCnt_o  out  16  recovery statistic.

Function
REQ-003 The block SHALL hold a circular buffer of NUM_CKPT entries, each {head value, valid, resolved}, with head pointer, tail pointer and count.
REQ-004 ckptTag_o SHALL equal the tail pointer; ckptFull_o SHALL be 1 exactly when count == NUM_CKPT.
REQ-005 Allocation occurs when branchValid_i & ~stall_i & ~ckptFull_o: entry[tail] <= {(freeListHead_i+branchOffset_i) mod SIZE_FREE_LIST, valid=1, resolved=0}; tail += 1 (mod NUM_CKPT); count += 1.
REQ-006 The mod SIZE_FREE_LIST SHALL be computed in FL_LOG+1 bits, subtracting SIZE_FREE_LIST once when the sum is >= SIZE_FREE_LIST.
REQ-007 A correct resolve (resolveValid_i & ~mispredict_i, entry valid) SHALL set entry[resolveTag_i].resolved.
REQ-008 Each cycle, if entry[head] is valid and resolved, it SHALL be invalidated, with head += 1 and count -= 1. At most one release per cycle, in order only.
REQ-009 A mispredict resolve on a valid entry SHALL set tail <= resolveTag_i, invalidate that entry and all younger entries, and set count <= (resolveTag_i - head) mod NUM_CKPT. The same-cycle release of REQ-008 is suppressed.
REQ-010 A mispredict resolve SHALL drop any same-cycle allocation.
REQ-011 A resolve on an invalid tag SHALL be ignored and produce no output pulse.
REQ-012 One cycle after an accepted resolve, ctrlVerified_o SHALL be 1 for exactly one cycle. flagRecoverEX_o SHALL equal the registered mispredict_i. freeListHeadCp_o SHALL hold the entry's stored head when mispredict_i=1, else its previous value.
REQ-013 recoverFlag_i SHALL invalidate all entries, set head=tail=count=0 and suppress same-cycle allocation and resolve pulses. It has priority over all other inputs.
REQ-014 Count SHALL never exceed NUM_CKPT or underflow. A simultaneous allocate and release leaves count unchanged.

Reset
REQ-015 While reset=1 (asynchronous), all of the following SHALL be 0: head, tail, count, every valid/resolved bit, ctrlVerified_o, flagRecoverEX_o, freeListHeadCp_o, fullStallCnt_o and recoverCnt_o.
REQ-016 Stored head values SHALL need no reset.

Configuration
REQ-017 With FLCKPT_STATS_EN defined, fullStallCnt_o SHALL count cycles with branchValid_i & ckptFull_o. recoverCnt_o SHALL count cycles with flagRecoverEX_o=1. Both are 16-bit, saturating at 16'hFFFF and cleared by reset or recoverFlag_i.
REQ-018 Without FLCKPT_STATS_EN, both statistic ports SHALL be constant 0 and no counter registers SHALL exist.

Verification
REQ-019 Reset, then 8 allocations with freeListHead_i=10, branchOffset_i=1 -> tags 0..7, ckptFull_o=1, ckptCount_o=8; a 9th allocation is refused with the tail unchanged.
REQ-020 freeListHead_i=94, branchOffset_i=4 -> stored head 2; a mispredict on that tag -> flagRecoverEX_o=1, freeListHeadCp_o=2 on the next cycle.
REQ-021 Tags 0,1,2 allocated; tag 1 resolved correct, then tag 0 resolved correct -> count goes 3,3,2,1 over successive cycles (in-order release).
REQ-022 Tags 0..4 allocated, mispredict on tag 2 with branchValid_i=1 in the same cycle -> tail=2, count=2, no allocation, ckptTag_o=2.
REQ-023 recoverFlag_i asserted together with resolveValid_i and mispredict_i -> count=0 and no ctrlVerified_o pulse. Reset asserted mid-stream clears all state without waiting for a clock edge.
REQ-024 With FLCKPT_STATS_EN: 3 cycles of branchValid_i while full, then 2 mispredicts -> fullStallCnt_o=3, recoverCnt_o=2. Without it, both read 0.
